// File: rtl/gcd_pkg.sv
// Shared types and constants for the streaming binary GCD engine.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMN  = 2'd1,
    RED  = 2'd2,
    DONE = 2'd3
  } state_t;

  // out_err encodings
  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_ZERO = 1'b1;

endpackage

// File: rtl/gcd_stream_binary_step.sv
// One reduction step of the binary GCD on odd/even operand pairs.
module gcd_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] next_a,
  output logic [WIDTH-1:0] next_b,
  output logic             eq
);

  // Priority: strip a factor of two from a, then from b, then subtract the
  // smaller odd value from the larger (the difference is even, so halve it).
  always_comb begin
    next_a = a;
    next_b = b;
    eq     = 1'b0;
    if (!a[0]) begin
      next_a = a >> 1;
    end else if (!b[0]) begin
      next_b = b >> 1;
    end else if (a == b) begin
      eq = 1'b1;
    end else if (a > b) begin
      next_a = (a - b) >> 1;
    end else begin
      next_b = (b - a) >> 1;
    end
  end

endmodule

// File: rtl/gcd_stream_binary.sv
// Streaming binary (Stein) GCD engine, one reduction step per clock.
//
//  state | meaning
//  IDLE  | in_ready=1, waiting for an operand pair
//  CMN   | removing common factors of two, counting them in k
//  RED   | reducing odd/even pair until a==b
//  DONE  | out_valid=1, result held until out_ready
module gcd_stream_binary
  import gcd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CYC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic [CYC_W-1:0] out_cycles
);

  localparam int K_W = $clog2(WIDTH+1);
  localparam logic [K_W-1:0]   K_ONE   = K_W'(1);
  localparam logic [CYC_W-1:0] CNT_ONE = CYC_W'(1);
  localparam logic [CYC_W-1:0] CNT_MAX = {CYC_W{1'b1}};

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [K_W-1:0]   k_q;
  logic [CYC_W-1:0] cnt_q;
  logic [CYC_W-1:0] cnt_inc;
  logic [WIDTH-1:0] step_a;
  logic [WIDTH-1:0] step_b;
  logic             step_eq;
  logic             in_zero;
  logic             both_even;

  gcd_step #(.WIDTH(WIDTH)) u_step (
    .a      (a_q),
    .b      (b_q),
    .next_a (step_a),
    .next_b (step_b),
    .eq     (step_eq)
  );

  assign in_zero   = (in_a == '0) || (in_b == '0);
  assign both_even = !a_q[0] && !b_q[0];
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = in_zero ? DONE : CMN;
      CMN:  if (!both_even) state_d = RED;
      RED:  if (step_eq) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath: operand capture, reduction, step counter and result latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      out_gcd    <= '0;
      out_err    <= ERR_NONE;
      out_cycles <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (in_zero) begin
              out_gcd    <= in_a | in_b;
              out_err    <= ((in_a | in_b) == '0) ? ERR_ZERO : ERR_NONE;
              out_cycles <= '0;
            end else begin
              a_q   <= in_a;
              b_q   <= in_b;
              k_q   <= '0;
              cnt_q <= '0;
            end
          end
        end
        CMN: begin
          cnt_q <= cnt_inc;
          if (both_even) begin
            a_q <= a_q >> 1;
            b_q <= b_q >> 1;
            k_q <= k_q + K_ONE;
          end
        end
        RED: begin
          cnt_q <= cnt_inc;
          a_q   <= step_a;
          b_q   <= step_b;
          if (step_eq) begin
            out_gcd    <= a_q << k_q;
            out_err    <= ERR_NONE;
            out_cycles <= cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_stream_binary.sv
// Directed and random checks for gcd_stream_binary at three parameter sets
// driven from one shared stimulus stream.
module tb_gcd_stream_binary;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;

  logic        rdy32, v32, e32;
  logic [31:0] g32;
  logic [7:0]  c32;
  logic        rdy8, v8, e8;
  logic [7:0]  g8;
  logic [7:0]  c8;
  logic        rdys, vs, es;
  logic [31:0] gs;
  logic [2:0]  cs;

  int pass_cnt = 0;
  int total_cnt = 0;
  int lat32;
  bit busy_low;
  bit timed_out;

  always #5 clk = ~clk;

  gcd_stream_binary #(.WIDTH(32), .CYC_W(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .in_a(in_a), .in_b(in_b), .out_valid(v32), .out_ready(out_ready),
    .out_gcd(g32), .out_err(e32), .out_cycles(c32)
  );

  gcd_stream_binary #(.WIDTH(8), .CYC_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .in_a(in_a[7:0]), .in_b(in_b[7:0]), .out_valid(v8), .out_ready(out_ready),
    .out_gcd(g8), .out_err(e8), .out_cycles(c8)
  );

  gcd_stream_binary #(.WIDTH(32), .CYC_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdys),
    .in_a(in_a), .in_b(in_b), .out_valid(vs), .out_ready(out_ready),
    .out_gcd(gs), .out_err(es), .out_cycles(cs)
  );

  function automatic logic [31:0] sw_gcd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Present one pair, wait (bounded) until all three engines hold a result.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!(rdy32 && rdy8 && rdys) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    busy_low = !rdy32;
    lat32 = v32 ? 0 : -1;
    n = 0;
    while (!(v32 && v8 && vs) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (v32 && lat32 < 0) lat32 = n;
    end
    timed_out = !(v32 && v8 && vs);
    total_cnt++;
    if (timed_out) $display("FAIL run_op_timeout a=%0d b=%0d got no out_valid want out_valid within 300 cycles", a, b);
    else pass_cnt++;
  endtask

  task automatic release_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_a = '0;
    in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({v32, e32, g32, c32} !== 42'd0) $display("FAIL reset_outputs got v=%b e=%b g=%0d c=%0d want all 0", v32, e32, g32, c32);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (rdy32 !== 1'b1 || v32 !== 1'b0) $display("FAIL reset_release got in_ready=%b out_valid=%b want 1 0", rdy32, v32);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    run_op(32'd12, 32'd18);
    total_cnt++;
    if (busy_low !== 1'b1) $display("FAIL basic_in_ready_busy got in_ready=%b want 0", !busy_low);
    else pass_cnt++;
    total_cnt++;
    if (g32 !== 32'd6 || e32 !== 1'b0) $display("FAIL basic_gcd got %0d err=%b want 6 err=0", g32, e32);
    else pass_cnt++;
    total_cnt++;
    if (c32 !== 8'd5 || lat32 != 5) $display("FAIL basic_cycles got cycles=%0d lat=%0d want 5 5", c32, lat32);
    else pass_cnt++;
    release_op();
  endtask

  task automatic test_zero();
    run_op(32'd0, 32'd45);
    total_cnt++;
    if (g32 !== 32'd45 || e32 !== 1'b0 || c32 !== 8'd0) $display("FAIL zero_one got g=%0d e=%b c=%0d want 45 0 0", g32, e32, c32);
    else pass_cnt++;
    total_cnt++;
    if (lat32 != 0) $display("FAIL zero_latency got %0d want 0 extra edges after accept", lat32);
    else pass_cnt++;
    release_op();
    run_op(32'd0, 32'd0);
    total_cnt++;
    if (g32 !== 32'd0 || e32 !== 1'b1) $display("FAIL zero_both got g=%0d e=%b want 0 1", g32, e32);
    else pass_cnt++;
    release_op();
    run_op(32'd7, 32'd0);
    total_cnt++;
    if (g32 !== 32'd7 || e32 !== 1'b0) $display("FAIL zero_b got g=%0d e=%b want 7 0", g32, e32);
    else pass_cnt++;
    release_op();
  endtask

  task automatic test_width8();
    logic [7:0] va [3] = '{8'd255, 8'd128, 8'd200};
    logic [7:0] vb [3] = '{8'd254, 8'd64,  8'd200};
    logic [7:0] vg [3] = '{8'd1,   8'd64,  8'd200};
    for (int i = 0; i < 3; i++) begin
      run_op({24'd0, va[i]}, {24'd0, vb[i]});
      total_cnt++;
      if (g8 !== vg[i] || e8 !== 1'b0) $display("FAIL w8_gcd_%0d got %0d want %0d", i, g8, vg[i]);
      else pass_cnt++;
      total_cnt++;
      if (c8 > 8'd18) $display("FAIL w8_cycles_%0d got %0d want <=18", i, c8);
      else pass_cnt++;
      total_cnt++;
      if (g32 !== {24'd0, vg[i]}) $display("FAIL w32_gcd_%0d got %0d want %0d", i, g32, vg[i]);
      else pass_cnt++;
      release_op();
    end
  endtask

  task automatic test_hold();
    run_op(32'd12, 32'd18);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      in_a = 32'd99;
      in_b = 32'd33;
      total_cnt++;
      if (v32 !== 1'b1 || rdy32 !== 1'b0 || g32 !== 32'd6 || c32 !== 8'd5 || e32 !== 1'b0)
        $display("FAIL hold_%0d got v=%b rdy=%b g=%0d c=%0d e=%b want 1 0 6 5 0", i, v32, rdy32, g32, c32, e32);
      else pass_cnt++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    total_cnt++;
    if (v32 !== 1'b0 || rdy32 !== 1'b1) $display("FAIL hold_release got v=%b rdy=%b want 0 1", v32, rdy32);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (v32 !== 1'b0 || rdy32 !== 1'b1) $display("FAIL hold_no_ghost got v=%b rdy=%b want 0 1", v32, rdy32);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    in_a = 32'h8000_0000;
    in_b = 32'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (v32 !== 1'b0 || rdy32 !== 1'b1) $display("FAIL areset_midred got v=%b rdy=%b want 0 1", v32, rdy32);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    total_cnt++;
    if (v32 !== 1'b0 || rdy32 !== 1'b1) $display("FAIL areset_aborted got v=%b rdy=%b want 0 1", v32, rdy32);
    else pass_cnt++;
    run_op(32'd12, 32'd18);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (v32 !== 1'b0 || g32 !== 32'd0) $display("FAIL areset_done got v=%b g=%0d want 0 0", v32, g32);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd21, 32'd14);
    total_cnt++;
    if (g32 !== 32'd7) $display("FAIL areset_next got %0d want 7", g32);
    else pass_cnt++;
    release_op();
  endtask

  task automatic test_saturate();
    run_op(32'h8000_0000, 32'd3);
    total_cnt++;
    if (cs !== 3'd7 || gs !== 32'd1) $display("FAIL sat_cycles got c=%0d g=%0d want 7 1", cs, gs);
    else pass_cnt++;
    total_cnt++;
    if (c32 !== 8'd34 || g32 !== 32'd1) $display("FAIL long_cycles got c=%0d g=%0d want 34 1", c32, g32);
    else pass_cnt++;
    total_cnt++;
    if (g8 !== 8'd3) $display("FAIL w8_trunc got %0d want 3", g8);
    else pass_cnt++;
    release_op();
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) begin
        a = a & 32'hFFFF_FF00;
        b = b & 32'hFFFF_F000;
      end
      exp = sw_gcd(a, b);
      run_op(a, b);
      total_cnt++;
      if (g32 !== exp || gs !== exp) $display("FAIL rand_%0d a=%0d b=%0d got %0d/%0d want %0d", i, a, b, g32, gs, exp);
      else pass_cnt++;
      release_op();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_width8();
    test_hold();
    test_async_reset();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
